// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage with a synchronous data RAM; loads take two
//            cycles (IDLE -> LOAD_WAIT), stores and ALU ops take one.
//            Optional macro MEM_ALIGN_CHK_EN flags misaligned loads/stores on err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ADDR_LEN       = 5,
  parameter int WORD_SIZE      = 32,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 reg_write_i,
  input  logic [ADDR_LEN-1:0]  dst_addr_i,
  input  logic [WORD_SIZE-1:0] alu_result_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  output logic                 valid_o,
  output logic [ADDR_LEN-1:0]  dst_addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 reg_write_o,
  output logic                 err_o
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 reg_write_q, reg_write_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [ADDR_LEN-1:0]  dst_q, dst_d;
  logic [ADDR_LEN-1:0]  ld_dst_q, ld_dst_d;
  logic                 ld_reg_write_q, ld_reg_write_d;
  logic [WORD_SIZE-1:0] rdata_q;

  logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  logic                      accept;
  logic                      misalign;
  logic                      mem_we;
  logic                      mem_re;
  logic [MEM_DEPTH_LOG2-1:0] word_idx;

  assign ready_o  = (state_q == IDLE);
  assign accept   = valid_i && ready_o;
  assign word_idx = alu_result_i[MEM_DEPTH_LOG2+1:2];

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = (mem_read_i || mem_write_i) && (alu_result_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A simultaneous read+write request is a store only.
  assign mem_we = accept && mem_write_i && !misalign;
  assign mem_re = accept && mem_read_i && !mem_write_i && !misalign;

  always_comb begin
    state_d        = state_q;
    valid_d        = 1'b0;
    reg_write_d    = 1'b0;
    err_d          = 1'b0;
    data_d         = data_q;
    dst_d          = dst_q;
    ld_dst_d       = ld_dst_q;
    ld_reg_write_d = ld_reg_write_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else if (mem_write_i) begin
            valid_d = 1'b1;
          end else if (mem_read_i) begin
            state_d        = LOAD_WAIT;
            ld_dst_d       = dst_addr_i;
            ld_reg_write_d = reg_write_i;
          end else begin
            valid_d     = 1'b1;
            data_d      = alu_result_i;
            dst_d       = dst_addr_i;
            reg_write_d = reg_write_i;
          end
        end
      end
      LOAD_WAIT: begin
        state_d     = IDLE;
        valid_d     = 1'b1;
        data_d      = rdata_q;
        dst_d       = ld_dst_q;
        reg_write_d = ld_reg_write_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      err_q          <= 1'b0;
      data_q         <= '0;
      dst_q          <= '0;
      ld_dst_q       <= '0;
      ld_reg_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      err_q          <= err_d;
      data_q         <= data_d;
      dst_q          <= dst_d;
      ld_dst_q       <= ld_dst_d;
      ld_reg_write_q <= ld_reg_write_d;
    end
  end

  // RAM contents survive reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[word_idx] <= store_data_i;
    end
    if (mem_re) begin
      rdata_q <= mem_q[word_idx];
    end
  end

  assign valid_o     = valid_q;
  assign reg_write_o = reg_write_q;
  assign err_o       = err_q;
  assign data_o      = data_q;
  assign dst_addr_o  = dst_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vectors, a transaction-level model checked
// every cycle, and literal expectations for the headline scenarios.
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        reg_write_i;
  logic [4:0]  dst_addr_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        valid_o;
  logic [4:0]  dst_addr_o;
  logic [31:0] data_o;
  logic        reg_write_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  mem_stage #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .dst_addr_i(dst_addr_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .valid_o(valid_o), .dst_addr_o(dst_addr_o), .data_o(data_o),
    .reg_write_o(reg_write_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_mem [256];
  bit          m_wr  [256];
  bit          pend;
  logic [31:0] p_data;
  bit          p_known;
  logic [4:0]  p_dst;
  bit          p_regw;
  bit          e_valid, e_regw, e_err, e_data_known, e_dst_known;
  logic [31:0] e_data;
  logic [4:0]  e_dst;

  always @(posedge clk) begin
    int  idx;
    bit  mis;
    cyc++;
    if (rst) begin
      e_valid = 0; e_regw = 0; e_err = 0; e_data = 0; e_dst = 0;
      e_data_known = 1; e_dst_known = 1; pend = 0;
    end else if (pend) begin
      e_valid = 1; e_err = 0; e_regw = p_regw;
      e_data = p_data; e_data_known = p_known;
      e_dst = p_dst; e_dst_known = 1; pend = 0;
    end else begin
      e_valid = 0; e_regw = 0; e_err = 0;
      if (valid_i) begin
        idx = int'((alu_result_i / 4) % 256);
        mis = 0;
`ifdef MEM_ALIGN_CHK_EN
        mis = (alu_result_i % 4) != 0;
`endif
        if ((mem_read_i || mem_write_i) && mis) begin
          e_valid = 1; e_err = 1; e_data_known = 0; e_dst_known = 0;
        end else if (mem_write_i) begin
          m_mem[idx] = store_data_i; m_wr[idx] = 1;
          e_valid = 1; e_data_known = 0; e_dst_known = 0;
        end else if (mem_read_i) begin
          pend = 1; p_data = m_mem[idx]; p_known = m_wr[idx];
          p_dst = dst_addr_i; p_regw = reg_write_i;
        end else begin
          e_valid = 1; e_regw = reg_write_i; e_data = alu_result_i; e_dst = dst_addr_i;
          e_data_known = 1; e_dst_known = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", {31'b0, ready_o}, {31'b0, !pend});
      check("valid_o", {31'b0, valid_o}, {31'b0, e_valid});
      check("reg_write_o", {31'b0, reg_write_o}, {31'b0, e_regw});
      check("err_o", {31'b0, err_o}, {31'b0, e_err});
      check("regw_without_valid", {31'b0, reg_write_o && !valid_o}, 32'd0);
      if (e_data_known) check("data_o", data_o, e_data);
      if (e_dst_known) check("dst_addr_o", {27'b0, dst_addr_o}, {27'b0, e_dst});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    valid_i = 1'b0;
    @(negedge clk);
  endtask

  // Present one instruction and hold it until it is accepted.
  task automatic send(input logic rd, input logic wr, input logic rw,
                      input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] sd);
    int guard = 0;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; reg_write_i = rw;
    dst_addr_i = dst; alu_result_i = alu; store_data_i = sd;
    while (ready_o !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready_o=%b expected 1", ready_o);
    end
    @(negedge clk);
  endtask

  int t1, t2;

  initial begin
    rst = 1'b1; valid_i = 1'b0; mem_read_i = 0; mem_write_i = 0; reg_write_i = 0;
    dst_addr_i = 0; alu_result_i = 0; store_data_i = 0;
    for (int i = 0; i < 256; i++) m_wr[i] = 0;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_data", data_o, 32'd0);
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU op, latency 1
    send(0, 0, 1, 5'd5, 32'h0000_1234, 32'h0);
    check("alu_valid", {31'b0, valid_o}, 32'd1);
    check("alu_data", data_o, 32'h0000_1234);
    check("alu_dst", {27'b0, dst_addr_o}, 32'd5);
    check("alu_regw", {31'b0, reg_write_o}, 32'd1);
    send(0, 0, 0, 5'd3, 32'hCAFE_0001, 32'h0);
    idle();
    check("hold_data", data_o, 32'hCAFE_0001);
    check("hold_valid", {31'b0, valid_o}, 32'd0);

    // Store then dependent load
    send(0, 1, 0, 5'd0, 32'h10, 32'hDEAD_BEEF);
    check("store_regw", {31'b0, reg_write_o}, 32'd0);
    send(1, 0, 1, 5'd7, 32'h10, 32'h0);
    check("load_ready_low", {31'b0, ready_o}, 32'd0);
    check("load_wait_valid", {31'b0, valid_o}, 32'd0);
    idle();
    check("load_data", data_o, 32'hDEAD_BEEF);
    check("load_dst", {27'b0, dst_addr_o}, 32'd7);
    check("load_valid", {31'b0, valid_o}, 32'd1);

    // Back-to-back loads with valid held
    send(0, 1, 0, 5'd0, 32'h20, 32'h1111_1111);
    send(0, 1, 0, 5'd0, 32'h24, 32'h2222_2222);
    send(1, 0, 1, 5'd21, 32'h20, 32'h0);
    t1 = cyc;
    send(1, 0, 1, 5'd22, 32'h24, 32'h0);
    t2 = cyc;
    check("b2b_spacing", t2 - t1, 32'd2);
    idle();
    check("b2b_second_data", data_o, 32'h2222_2222);
    check("b2b_second_dst", {27'b0, dst_addr_o}, 32'd22);

    // Simultaneous read+write is a store only
    send(1, 1, 1, 5'd4, 32'h30, 32'h0000_0077);
    check("rw_ready", {31'b0, ready_o}, 32'd1);
    check("rw_regw", {31'b0, reg_write_o}, 32'd0);
    send(1, 0, 1, 5'd8, 32'h30, 32'h0);
    idle();
    check("rw_load_data", data_o, 32'h0000_0077);

    // Upper address bits ignored
    send(0, 1, 0, 5'd0, 32'h0000_0450, 32'h1234_5678);
    send(1, 0, 1, 5'd9, 32'h0000_0050, 32'h0);
    idle();
    check("wrap_load_data", data_o, 32'h1234_5678);

    // Reset during LOAD_WAIT, then reset blocks a store
    send(0, 1, 0, 5'd0, 32'h40, 32'hAAAA_5555);
    send(1, 0, 1, 5'd9, 32'h40, 32'h0);
    rst = 1'b1;
    valid_i = 1'b1; mem_read_i = 0; mem_write_i = 1; alu_result_i = 32'h40; store_data_i = 32'h0000_0BAD;
    @(negedge clk);
    check("rst_lw_valid", {31'b0, valid_o}, 32'd0);
    check("rst_lw_regw", {31'b0, reg_write_o}, 32'd0);
    check("rst_lw_ready", {31'b0, ready_o}, 32'd1);
    check("rst_lw_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    check("rst_abandon_valid", {31'b0, valid_o}, 32'd0);
    send(1, 0, 1, 5'd10, 32'h40, 32'h0);
    idle();
    check("rst_store_blocked", data_o, 32'hAAAA_5555);

`ifdef MEM_ALIGN_CHK_EN
    send(0, 1, 0, 5'd0, 32'h12, 32'h0000_0005);
    check("mis_err", {31'b0, err_o}, 32'd1);
    check("mis_regw", {31'b0, reg_write_o}, 32'd0);
    idle();
    check("mis_err_one_cycle", {31'b0, err_o}, 32'd0);
    send(1, 0, 1, 5'd11, 32'h10, 32'h0);
    check("mis_no_waitstate", {31'b0, ready_o}, 32'd0);
    idle();
    check("mis_word_unchanged", data_o, 32'hDEAD_BEEF);
`else
    send(0, 1, 0, 5'd0, 32'h13, 32'h0000_0005);
    check("unaligned_err", {31'b0, err_o}, 32'd0);
    send(1, 0, 1, 5'd11, 32'h10, 32'h0);
    idle();
    check("unaligned_data", data_o, 32'h0000_0005);
    check("unaligned_err_load", {31'b0, err_o}, 32'd0);
`endif

    idle();
    idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_LEN, default 5, register-file destination address width.
REQ-002 Parameter WORD_SIZE, default 32, data word width.
REQ-003 Parameter MEM_DEPTH_LOG2, default 8, log2 of data-memory depth in words.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 valid_i  input  1  upstream instruction valid.
REQ-007 ready_o  output  1  stage can accept; low means upstream holds its inputs.
REQ-008 mem_read_i  input  1  instruction is a load.
REQ-009 mem_write_i  input  1  instruction is a store.
REQ-010 reg_write_i  input  1  instruction writes a register.
REQ-011 dst_addr_i  input  ADDR_LEN  destination register.
REQ-012 alu_result_i  input  WORD_SIZE  byte address for load/store, else result.
REQ-013 store_data_i  input  WORD_SIZE  store data.
REQ-014 valid_o  output  1  output bundle valid toward write-back.
REQ-015 dst_addr_o  output  ADDR_LEN  registered destination register.
REQ-016 data_o  output  WORD_SIZE  registered write-back data.
REQ-017 reg_write_o  output  1  registered register-write request; never 1 while valid_o is 0.
REQ-018 err_o  output  1  misaligned-access flag (see Configuration).

Function
REQ-019 Accept = valid_i && ready_o, sampled at the rising edge.
REQ-020 FSM states IDLE, LOAD_WAIT; ready_o = 1 in IDLE, 0 in LOAD_WAIT (combinational from state).
REQ-021 Word index = alu_result_i[MEM_DEPTH_LOG2+1:2]; higher bits ignored.
REQ-022 Accepted non-memory op: next cycle valid_o=1, data_o=alu_result_i, dst_addr_o=dst_addr_i, reg_write_o=reg_write_i; latency 1.
REQ-023 Accepted store: memory word written at the accepting edge; next cycle valid_o=1, reg_write_o=0.
REQ-024 mem_read_i and mem_write_i both high: treated as store only; no read, no LOAD_WAIT.
REQ-025 Accepted load: synchronous memory read issued; dst_addr_i, reg_write_i latched; IDLE->LOAD_WAIT.
REQ-026 LOAD_WAIT: valid_o=0, reg_write_o=0; at its end data_o=read word, dst_addr_o=latched dst, reg_write_o=latched reg_write, valid_o=1; LOAD_WAIT->IDLE unconditionally.
REQ-027 Load latency 2 cycles; back-to-back loads accepted every 2 cycles.
REQ-028 No accept in a cycle: next cycle valid_o=0, reg_write_o=0; data_o and dst_addr_o hold.
REQ-029 Load reading an address stored by the immediately preceding accepted store returns the new data (store completes before read issues).
REQ-030 No downstream back-pressure; write-back always consumes valid_o.

Reset
REQ-031 rst high at an edge: state=IDLE, valid_o=0, reg_write_o=0, data_o=0, dst_addr_o=0, err_o=0.
REQ-032 rst asserted during LOAD_WAIT abandons the load; no valid_o produced for it.
REQ-033 rst has priority over accept; a store presented during rst is not written.
REQ-034 Data-memory contents are not reset.

Configuration
REQ-035 Macro MEM_ALIGN_CHK_EN: when defined, accepted load/store with alu_result_i[1:0]!=0 performs no memory access, no LOAD_WAIT; next cycle valid_o=1, reg_write_o=0, err_o=1 for that one cycle.
REQ-036 Without MEM_ALIGN_CHK_EN: alu_result_i[1:0] ignored, access to the truncated word index, err_o tied 0.

Verification
REQ-037 Reset then valid_i=1 ALU op alu_result_i=0x0000_1234, dst=5, reg_write=1 -> next cycle valid_o=1, data_o=0x0000_1234, dst_addr_o=5, reg_write_o=1.
REQ-038 Store 0xDEAD_BEEF to address 0x10, next cycle load 0x10 dst=7 -> ready_o=0 one cycle, then valid_o=1, data_o=0xDEAD_BEEF, dst_addr_o=7.
REQ-039 Two loads presented back-to-back with valid_i held -> second accepted only after ready_o returns 1; two valid_o pulses 2 cycles apart.
REQ-040 rst pulsed in LOAD_WAIT -> following cycle valid_o=0, reg_write_o=0, ready_o=1, data_o=0.
REQ-041 MEM_ALIGN_CHK_EN defined, store to 0x12 then load 0x10 -> store gives err_o=1, reg_write_o=0; load returns prior contents of word 4, unchanged.
REQ-042 Macro undefined, store 0x5 to 0x13 then load 0x10 -> data_o=0x5, err_o=0.
